// File: rtl/sign_extend_pkg.sv
// sign_extend_pkg: shared widths and immediate format encoding for the RV64 immediate generator.
package sign_extend_pkg;
   localparam int XLEN = 64;
   localparam int ILEN = 32;
   typedef enum logic [2:0] {
      IMM_I  = 3'd0,
      IMM_S  = 3'd1,
      IMM_SB = 3'd2,
      IMM_U  = 3'd3,
      IMM_UJ = 3'd4,
      IMM_SH = 3'd5
   } imm_sel_e;
endpackage

// File: rtl/sign_extend_imm_gen_comb.sv
// imm_gen_comb: extracts the immediate field of an instruction and extends it to XLEN bits.
module imm_gen_comb
   import sign_extend_pkg::*;
(
   input  logic [ILEN-1:0] instruction,
   input  logic [2:0]      sel_type,
   output logic [XLEN-1:0] imm
);
   logic s;
   logic unused_opcode;
   assign s = instruction[31];
   assign unused_opcode = ^instruction[6:0];
   always_comb begin
      imm = '0;
      case (imm_sel_e'(sel_type))
         IMM_I:  imm = {{52{s}}, instruction[31:20]};
         IMM_S:  imm = {{52{s}}, instruction[31:25], instruction[11:7]};
         IMM_SB: imm = {{51{s}}, s, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
         IMM_U:  imm = {{32{s}}, instruction[31:12], 12'h000};
         IMM_UJ: imm = {{43{s}}, s, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
         IMM_SH: imm = {58'h0, instruction[25:20]};
         default: imm = '0;
      endcase
   end
endmodule

// File: rtl/sign_extend.sv
// sign_extend: registered RV64 immediate generator with synchronous active-high reset.
module sign_extend
   import sign_extend_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [ILEN-1:0] instruction,
   input  logic [2:0]      sel_type,
   output logic [XLEN-1:0] extension
);
   logic [XLEN-1:0] imm;
   imm_gen_comb u_imm_gen (
      .instruction(instruction),
      .sel_type   (sel_type),
      .imm        (imm)
   );
   always_ff @(posedge clk) begin
      if (reset) extension <= '0;
      else       extension <= imm;
   end
endmodule

// File: tb/tb_sign_extend.sv
// tb_sign_extend: directed vectors with hand-computed immediates for sign_extend.
module tb_sign_extend;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic [2:0]  sel_type;
   logic [63:0] extension;
   int checks = 0;
   int failures = 0;

   sign_extend dut (
      .clk        (clk),
      .reset      (reset),
      .instruction(instruction),
      .sel_type   (sel_type),
      .extension  (extension)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive inputs, then confirm the output is unchanged before the edge and updated after it.
   task automatic apply(input string tag, input logic [31:0] ins, input logic [2:0] sel,
                        input logic [63:0] exp);
      logic [63:0] prev;
      prev = extension;
      instruction = ins;
      sel_type = sel;
      #1 check({tag, "_hold"}, extension, prev);
      @(posedge clk);
      #1 check(tag, extension, exp);
   endtask

   initial begin
      reset = 1'b1;
      instruction = 32'hFFFFFFFF;
      sel_type = 3'd0;
      repeat (2) @(posedge clk);
      #1 check("reset", extension, 64'h0);
      @(posedge clk);
      #1 check("reset_hold", extension, 64'h0);
      reset = 1'b0;
      apply("i_neg",   32'hF0000000, 3'd0, 64'hFFFFFFFFFFFFFF00);
      apply("s_neg",   32'hF0000000, 3'd1, 64'hFFFFFFFFFFFFFF00);
      apply("sb_neg",  32'hF0000000, 3'd2, 64'hFFFFFFFFFFFFF700);
      apply("u_neg",   32'hF0000000, 3'd3, 64'hFFFFFFFFF0000000);
      apply("uj_neg",  32'hF0000000, 3'd4, 64'hFFFFFFFFFFF00700);
      apply("sh_zero", 32'hF0000000, 3'd5, 64'h0);
      apply("i_pos",   32'h7FF00000, 3'd0, 64'h00000000000007FF);
      apply("sh_pos",  32'h03F00013, 3'd5, 64'h000000000000003F);
      apply("i_ones",  32'hFFFFFFFF, 3'd0, 64'hFFFFFFFFFFFFFFFF);
      apply("rsv6",    32'hFFFFFFFF, 3'd6, 64'h0);
      apply("s_ones",  32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF);
      apply("rsv7",    32'hFFFFFFFF, 3'd7, 64'h0);
      apply("sb_ones", 32'hFFFFFFFF, 3'd2, 64'hFFFFFFFFFFFFFFFE);
      apply("u_ones",  32'hFFFFFFFF, 3'd3, 64'hFFFFFFFFFFFFF000);
      apply("uj_ones", 32'hFFFFFFFF, 3'd4, 64'hFFFFFFFFFFFFFFFE);
      apply("sh_ones", 32'hFFFFFFFF, 3'd5, 64'h000000000000003F);
      apply("b2b_0",   32'hF0000000, 3'd0, 64'hFFFFFFFFFFFFFF00);
      apply("b2b_1",   32'hF0000000, 3'd1, 64'hFFFFFFFFFFFFFF00);
      apply("b2b_2",   32'hF0000000, 3'd2, 64'hFFFFFFFFFFFFF700);
      reset = 1'b1;
      apply("mid_rst", 32'hF0000000, 3'd3, 64'h0);
      reset = 1'b0;
      apply("b2b_3",   32'hF0000000, 3'd3, 64'hFFFFFFFFF0000000);
      apply("b2b_4",   32'hF0000000, 3'd4, 64'hFFFFFFFFFFF00700);
      apply("b2b_5",   32'hF0000000, 3'd5, 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
